qrisc32_mem_arbiter: RTL

- Shares one single-port synchronous SRAM between three requesters: instruction fetch (read), MEM-stage data read and MEM-stage data write.
- Sits between the core's fetch and MEM stages and the data/instruction SRAM.
- Serialises accesses, handles the fixed SRAM access latency, and returns read data and completion through per-requester wait_req.

---
 rtl/qrisc32_mem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/qrisc32_mem_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between fetch, data read and data write.
// Optional macro QRISC32_ARB_RR_EN selects round-robin arbitration with a read-after-write hazard mask.
//
// state | meaning
// IDLE  | no access in flight; pick a winner and register the SRAM request
// ISSUE | SRAM strobe high for this cycle; latency counter loaded
// WAIT  | waiting out the remaining SRAM latency
// DONE  | read data valid on sram_data_r; winner's wait_req released
module qrisc32_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          i_rd,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_data_r,
    output logic          i_wait_req,
    input  logic          d_rd,
    input  logic [AW-1:0] d_raddr,
    output logic [DW-1:0] d_data_r,
    output logic          d_rwait_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_waddr,
    input  logic [DW-1:0] d_data_w,
    output logic          d_wwait_req,
    output logic [AW-1:0] sram_addr,
    output logic          sram_rd,
    output logic          sram_wr,
    output logic [DW-1:0] sram_data_w,
    input  logic [DW-1:0] sram_data_r,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] G_NONE  = 2'd0;
    localparam logic [1:0] G_FETCH = 2'd1;
    localparam logic [1:0] G_DRD   = 2'd2;
    localparam logic [1:0] G_DWR   = 2'd3;
    localparam logic [2:0] LAT_M1  = 3'(LATENCY - 1);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_data_q, i_data_d;
    logic [DW-1:0] d_data_q, d_data_d;
    logic [1:0]    winner;
    logic          done;

`ifdef QRISC32_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic       rd_ok;

    // A read that aliases a pending write must wait so it observes the new value.
    assign rd_ok = d_rd && !(d_wr && (d_raddr == d_waddr));

    always_comb begin
        winner = G_NONE;
        case (ptr_q)
            G_DRD: begin
                if (rd_ok)     winner = G_DRD;
                else if (d_wr) winner = G_DWR;
                else if (i_rd) winner = G_FETCH;
            end
            G_DWR: begin
                if (d_wr)       winner = G_DWR;
                else if (i_rd)  winner = G_FETCH;
                else if (rd_ok) winner = G_DRD;
            end
            default: begin
                if (i_rd)       winner = G_FETCH;
                else if (rd_ok) winner = G_DRD;
                else if (d_wr)  winner = G_DWR;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_DONE) ptr_d = (grant_q == G_DWR) ? G_FETCH : grant_q + 2'd1;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) ptr_q <= G_FETCH;
        else           ptr_q <= ptr_d;
    end
`else
    // Write first keeps read-after-write ordering for the same address.
    always_comb begin
        winner = G_NONE;
        if (d_wr)      winner = G_DWR;
        else if (d_rd) winner = G_DRD;
        else if (i_rd) winner = G_FETCH;
    end
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        wdata_d  = wdata_q;
        i_data_d = i_data_q;
        d_data_d = d_data_q;
        case (state_q)
            S_IDLE: begin
                if (winner != G_NONE) begin
                    grant_d = winner;
                    rd_d    = (winner != G_DWR);
                    wr_d    = (winner == G_DWR);
                    case (winner)
                        G_DWR: begin
                            addr_d  = d_waddr;
                            wdata_d = d_data_w;
                        end
                        G_DRD:   addr_d = d_raddr;
                        default: addr_d = i_addr;
                    endcase
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = S_DONE;
            end
            default: begin
                if (grant_q == G_FETCH) i_data_d = sram_data_r;
                if (grant_q == G_DRD)   d_data_d = sram_data_r;
                grant_d = G_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= S_IDLE;
            grant_q  <= G_NONE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            i_data_q <= i_data_d;
            d_data_q <= d_data_d;
        end
    end

    // Read data is forwarded in the DONE cycle itself, then held in the register.
    assign done        = (state_q == S_DONE);
    assign i_data_r    = (done && grant_q == G_FETCH) ? sram_data_r : i_data_q;
    assign d_data_r    = (done && grant_q == G_DRD)   ? sram_data_r : d_data_q;
    assign i_wait_req  = i_rd && !(done && grant_q == G_FETCH);
    assign d_rwait_req = d_rd && !(done && grant_q == G_DRD);
    assign d_wwait_req = d_wr && !(done && grant_q == G_DWR);
    assign sram_addr   = addr_q;
    assign sram_rd     = rd_q;
    assign sram_wr     = wr_q;
    assign sram_data_w = wdata_q;
    assign grant       = grant_q;

endmodule
